neuron_lut_loader: RTL and testbench
====================================

Name: neuron_lut_loader

Overview:
- Runtime-programmable single-output neuron truth table for LogicNets-style layers. It is the writer side of the fixed case-statement neuron ROMs.
- A configuration stream loads the 2^IN_BITS-entry, 1-bit truth table word by word. Once loaded, the block serves registered lookups: IN_BITS-bit input code in, 1-bit activation out.
- Sits between the layer configuration bus and the layer datapath. A layer can be retrained and reloaded without resynthesis.

Parameters:
- IN_BITS, 8, width of lookup input code; table depth ENTRIES = 2**IN_BITS.
- CFG_W, 8, configuration word width; ENTRIES must be divisible by CFG_W, NWORDS = ENTRIES/CFG_W (default 32).

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst  in  1  synchronous, active-low reset.
- cfg_start  in  1  pulse; begins (or restarts) a table load.
- cfg_valid  in  1  config word valid.
- cfg_ready  out  1  loader accepts a word this cycle.
- cfg_data  in  CFG_W  config word; bit j of word k -> table address k*CFG_W+j.
- loaded  out  1  table complete and lookups enabled.
- popcount  out  IN_BITS+1  number of 1 entries written in the current/last load.
- in_valid  in  1  lookup request.
- in_ready  out  1  lookup accepted when in_valid&in_ready.
- M0  in  IN_BITS  lookup input code.
- out_valid  out  1  M1 valid (1-cycle pulse per accepted lookup).
- M1  out  1  table[M0] registered.

Behaviour:
- Reset (rst=0 at an edge) forces:
  - state IDLE; word counter 0; popcount 0.
  - loaded 0, cfg_ready 0, in_ready 0, out_valid 0, M1 0.
  - Table storage is not cleared; its contents are don't-care until the next full load.
- Reset mid-load abandons the load. loaded stays 0 until a complete new load.
- State IDLE:
  - cfg_ready=0, in_ready=0.
  - cfg_start -> LOAD next cycle, with counter=0 and popcount=0.
  - A cfg_valid without a prior cfg_start is ignored.
- State LOAD:
  - cfg_ready=1; loaded=0; in_ready=0.
  - Each cfg_valid cycle writes CFG_W bits at base counter*CFG_W, adds popcount(cfg_data) to popcount, and increments counter.
  - Accepting word NWORDS-1 -> ACTIVE next cycle. loaded=1 in that same next cycle, and popcount holds the final total.
  - cfg_start in LOAD (with or without cfg_valid) restarts the load: counter=0, popcount=0, and any word presented that cycle is dropped.
- State ACTIVE:
  - in_ready=1; cfg_ready=0.
  - Accepted lookup at cycle t -> out_valid=1 and M1=table[M0 sampled at t] at cycle t+1. Latency is exactly 1 cycle.
  - No output backpressure; back-to-back lookups give one result per cycle.
  - out_valid=0 and M1 holds its previous value in any cycle without a result.
  - cfg_start -> LOAD next cycle; loaded drops to 0 in that cycle.
  - A lookup accepted in the same cycle as cfg_start completes normally with the old table value.
- cfg_start has priority over everything except reset.
- Counter width is clog2(NWORDS). It never wraps, because the LOAD->ACTIVE transition occurs on the last word.
- popcount saturates naturally at ENTRIES (fits in IN_BITS+1 bits).
- Storage is distributed RAM (rom_style/ram_style "distributed"): 1 write port of CFG_W bits, 1 read port of 1 bit.

Test Plan:
- Reset and idle: hold rst=0 for 3 cycles, then release. Drive in_valid=1, M0=8'h00, and cfg_valid=1 with no cfg_start. Expected: loaded=0, in_ready=0, cfg_ready=0, out_valid never asserts, popcount=0.
- Full load and lookup:
  - Stimulus: cfg_start, then 32 words with word0=8'h00, word1=8'hC3, words2..31=8'hFF.
  - Expected: loaded=1 one cycle after the last word; popcount=244.
  - Lookups: M0=8'h05 -> M1=0; M0=8'h08 -> M1=1; M0=8'h0A -> M1=0; M0=8'hFF -> M1=1. Each result appears exactly 1 cycle after acceptance.
- Gapped stream: same load as above, with cfg_valid low on alternate cycles. Expected: identical table and popcount=244; the LOAD->ACTIVE transition occurs only after the 32nd accepted word.
- Restart mid-load: after 10 words, assert cfg_start together with cfg_valid and cfg_data=8'hAA. Expected: that word is dropped and popcount=0 next cycle. A full all-8'h0F load then gives popcount=128, and M0=8'h03 -> 1, M0=8'h04 -> 0.
- Reload while active: with the table loaded, accept a lookup with M0=8'h08 in the same cycle as cfg_start. Expected: out_valid=1 with the old value M1=1 next cycle; loaded=0 that cycle; in_ready=0 during the entire LOAD.
- Reset mid-load: assert rst=0 after word 5. Expected: IDLE, loaded=0, popcount=0; a subsequent full load completes normally.

Source files
------------

// File: rtl/neuron_lut_loader.sv
// Runtime-loadable 2^IN_BITS x 1 neuron truth table: a word-serial config stream fills the table,
// then registered single-cycle lookups are served. CFG_W and NWORDS must both be >= 2.
module neuron_lut_loader #(
  parameter int unsigned IN_BITS = 8,
  parameter int unsigned CFG_W   = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_start,
  input  logic               cfg_valid,
  output logic               cfg_ready,
  input  logic [CFG_W-1:0]   cfg_data,
  output logic               loaded,
  output logic [IN_BITS:0]   popcount,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [IN_BITS-1:0] M0,
  output logic               out_valid,
  output logic               M1
);

  localparam int unsigned ENTRIES = 2 ** IN_BITS;
  localparam int unsigned NWORDS  = ENTRIES / CFG_W;
  localparam int unsigned CNT_W   = $clog2(NWORDS);
  localparam int unsigned SEL_W   = $clog2(CFG_W);

  localparam logic [1:0] IDLE   = 2'd0;
  localparam logic [1:0] LOAD   = 2'd1;
  localparam logic [1:0] ACTIVE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IN_BITS:0] pop_q, pop_d;
  logic [IN_BITS:0] word_ones;
  logic             wr_en;
  logic             lookup;

  (* ram_style = "distributed" *) logic [CFG_W-1:0] mem [NWORDS];

  always_comb begin
    word_ones = '0;
    for (int j = 0; j < int'(CFG_W); j++) begin
      word_ones = word_ones + (IN_BITS + 1)'(cfg_data[j]);
    end
  end

  // cfg_start wins over any word presented in the same cycle, which is dropped.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pop_d   = pop_q;
    wr_en   = 1'b0;
    if (cfg_start) begin
      state_d = LOAD;
      cnt_d   = '0;
      pop_d   = '0;
    end else if (state_q == LOAD && cfg_valid) begin
      wr_en = 1'b1;
      pop_d = pop_q + word_ones;
      if (cnt_q == CNT_W'(NWORDS - 1)) begin
        state_d = ACTIVE;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  assign cfg_ready = (state_q == LOAD);
  assign in_ready  = (state_q == ACTIVE);
  assign loaded    = (state_q == ACTIVE);
  assign popcount  = pop_q;
  assign lookup    = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      pop_q     <= '0;
      out_valid <= 1'b0;
      M1        <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      pop_q     <= pop_d;
      out_valid <= lookup;
      if (lookup) begin
        M1 <= mem[M0[IN_BITS-1:SEL_W]][M0[SEL_W-1:0]];
      end
    end
  end

  // Storage is deliberately not reset; contents are meaningless until a full load completes.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[cnt_q] <= cfg_data;
    end
  end

endmodule

// File: tb/tb_neuron_lut_loader.sv
// Directed bench for neuron_lut_loader: reset/idle, full and gapped loads, restarts, reload while
// active, reset mid-load, with table-driven lookup vectors.
module tb_neuron_lut_loader;

  logic       clk = 1'b0;
  logic       rst;
  logic       cfg_start;
  logic       cfg_valid;
  logic       cfg_ready;
  logic [7:0] cfg_data;
  logic       loaded;
  logic [8:0] popcount;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] M0;
  logic       out_valid;
  logic       M1;

  int checks = 0;
  int errors = 0;

  neuron_lut_loader #(.IN_BITS(8), .CFG_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .cfg_start (cfg_start),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_data  (cfg_data),
    .loaded    (loaded),
    .popcount  (popcount),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .M0        (M0),
    .out_valid (out_valid),
    .M1        (M1)
  );

  always #5 clk = ~clk;

  // Table A: word0=00, word1=C3, words2..31=FF. Table B: every word 0F.
  typedef struct {
    logic [7:0] m0;
    logic       m1_a;
    logic       m1_b;
  } lut_vec_t;

  lut_vec_t vecs [11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] word_of(input int mode, input int k);
    if (mode == 1) return 8'h0F;
    if (k == 0) return 8'h00;
    if (k == 1) return 8'hC3;
    return 8'hFF;
  endfunction

  // Streams 32 words; optional leading cfg_start and idle gaps between words.
  task automatic do_load(input int mode, input bit send_start, input bit gapped,
                         input int exp_pop);
    if (send_start) begin
      cfg_start = 1'b1;
      step();
      cfg_start = 1'b0;
      chk("start_pop_zero", 32'(popcount), 0);
    end
    for (int k = 0; k < 32; k++) begin
      chk("load_cfg_ready", 32'(cfg_ready), 1);
      chk("load_in_ready", 32'(in_ready), 0);
      if (gapped) begin
        cfg_valid = 1'b0;
        step();
        chk("gap_loaded", 32'(loaded), 0);
      end
      cfg_valid = 1'b1;
      cfg_data  = word_of(mode, k);
      step();
      if (k < 31) chk("loaded_early", 32'(loaded), 0);
    end
    cfg_valid = 1'b0;
    chk("loaded_after_last", 32'(loaded), 1);
    chk("final_popcount", 32'(popcount), 32'(exp_pop));
    chk("active_cfg_ready", 32'(cfg_ready), 0);
  endtask

  // Back-to-back lookups, then an idle cycle where M1 must hold.
  task automatic run_lookups(input bit use_b);
    logic last;
    last = 1'b0;
    for (int i = 0; i < 11; i++) begin
      in_valid = 1'b1;
      M0       = vecs[i].m0;
      chk("in_ready_active", 32'(in_ready), 1);
      step();
      last = use_b ? vecs[i].m1_b : vecs[i].m1_a;
      chk("lookup_valid", 32'(out_valid), 1);
      chk($sformatf("lookup_m1_%02h", vecs[i].m0), 32'(M1), 32'(last));
    end
    in_valid = 1'b0;
    M0       = 8'h00;
    step();
    chk("idle_out_valid", 32'(out_valid), 0);
    chk("idle_m1_hold", 32'(M1), 32'(last));
  endtask

  initial begin
    vecs[0]  = '{8'h05, 1'b0, 1'b0};
    vecs[1]  = '{8'h08, 1'b1, 1'b1};
    vecs[2]  = '{8'h0A, 1'b0, 1'b1};
    vecs[3]  = '{8'hFF, 1'b1, 1'b0};
    vecs[4]  = '{8'h03, 1'b0, 1'b1};
    vecs[5]  = '{8'h04, 1'b0, 1'b0};
    vecs[6]  = '{8'h0E, 1'b1, 1'b0};
    vecs[7]  = '{8'h0B, 1'b0, 1'b1};
    vecs[8]  = '{8'h10, 1'b1, 1'b1};
    vecs[9]  = '{8'h77, 1'b1, 1'b0};
    vecs[10] = '{8'h09, 1'b1, 1'b1};

    rst = 1'b0; cfg_start = 1'b0; cfg_valid = 1'b0; cfg_data = 8'h00;
    in_valid = 1'b0; M0 = 8'h00;
    repeat (3) step();
    chk("rst_loaded", 32'(loaded), 0);
    chk("rst_cfg_ready", 32'(cfg_ready), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_m1", 32'(M1), 0);
    chk("rst_popcount", 32'(popcount), 0);

    // Idle: stray lookups and config words without cfg_start are ignored.
    rst = 1'b1; in_valid = 1'b1; M0 = 8'h00; cfg_valid = 1'b1; cfg_data = 8'hFF;
    for (int i = 0; i < 4; i++) begin
      step();
      chk("idle_out_valid", 32'(out_valid), 0);
      chk("idle_loaded", 32'(loaded), 0);
      chk("idle_in_ready", 32'(in_ready), 0);
      chk("idle_cfg_ready", 32'(cfg_ready), 0);
      chk("idle_popcount", 32'(popcount), 0);
    end
    in_valid = 1'b0; cfg_valid = 1'b0;

    do_load(0, 1'b1, 1'b0, 244);
    run_lookups(1'b0);

    do_load(0, 1'b1, 1'b1, 244);
    run_lookups(1'b0);

    // Reload while active: lookup in the cfg_start cycle returns the old table value.
    in_valid = 1'b1; M0 = 8'h0A; cfg_start = 1'b1;
    step();
    in_valid = 1'b0; cfg_start = 1'b0;
    chk("reload_out_valid", 32'(out_valid), 1);
    chk("reload_old_m1", 32'(M1), 0);
    chk("reload_loaded", 32'(loaded), 0);
    chk("reload_in_ready", 32'(in_ready), 0);
    chk("reload_popcount", 32'(popcount), 0);
    do_load(1, 1'b0, 1'b0, 128);
    run_lookups(1'b1);

    // Restart mid-load: the word presented with cfg_start is dropped.
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int k = 0; k < 10; k++) begin
      cfg_valid = 1'b1; cfg_data = 8'hFF;
      step();
    end
    chk("partial_popcount", 32'(popcount), 80);
    cfg_start = 1'b1; cfg_valid = 1'b1; cfg_data = 8'hAA;
    step();
    cfg_start = 1'b0; cfg_valid = 1'b0;
    chk("restart_popcount", 32'(popcount), 0);
    chk("restart_cfg_ready", 32'(cfg_ready), 1);
    chk("restart_loaded", 32'(loaded), 0);
    do_load(1, 1'b0, 1'b0, 128);
    run_lookups(1'b1);

    // Reset mid-load abandons the load.
    cfg_start = 1'b1;
    step();
    cfg_start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cfg_valid = 1'b1; cfg_data = 8'hFF;
      step();
    end
    cfg_valid = 1'b0; rst = 1'b0;
    step();
    rst = 1'b1;
    chk("midrst_loaded", 32'(loaded), 0);
    chk("midrst_popcount", 32'(popcount), 0);
    chk("midrst_cfg_ready", 32'(cfg_ready), 0);
    cfg_valid = 1'b1; cfg_data = 8'hFF;
    step();
    cfg_valid = 1'b0;
    chk("midrst_idle_ignore", 32'(popcount), 0);
    do_load(0, 1'b1, 1'b0, 244);
    run_lookups(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
